node0: RTL and testbench
========================

Name: node0

Overview:
- Leaf computation node of the "operation o" composition datapath: evaluates f(g0(x), g1(x), g2(x)) over three 16-bit operands.
- x = (IN0, IN1, IN2).
- Start/ready handshake (ST/RD) so a parent scheduler can chain nodes.
- Fixed three-clock latency from accepted start to result.

Parameters:
- WIDTH, 16, operand and result width. All arithmetic is modulo 2^WIDTH.

Ports:
- CLK  input  1  rising-edge clock; the only clock.
- RST  input  1  synchronous, active-low reset, sampled on the CLK rising edge.
- ST  input  1  start request; sampled on the rising edge.
- RD  output  1  ready: result valid on RES.
- RES  output  WIDTH  result f(g0,g1,g2).
- IN0  input  WIDTH  operand x0.
- IN1  input  WIDTH  operand x1.
- IN2  input  WIDTH  operand x2.

Behaviour:
- Functions, all results truncated to the low WIDTH bits:
  - g0 = IN0 + IN1
  - g1 = IN1 * IN2
  - g2 = IN2 - IN0 (two's-complement wrap)
  - f = g0 + g1 + g2
- Reset: when RST=0 at a rising edge:
  - state goes to IDLE; RD=0; RES=0; operand and g registers are cleared.
  - Reset has priority over everything, including mid-operation; the in-flight result is discarded.
- State machine: IDLE -> LOAD -> EVAL_G -> EVAL_F -> DONE.
  - IDLE: ST=1 at an edge latches IN0..IN2 into operand registers; go to EVAL_G.
  - EVAL_G: next edge registers g0/g1/g2; go to EVAL_F.
  - EVAL_F: next edge registers RES=f and sets RD=1; go to DONE.
  - LOAD is the latch action performed on the IDLE->EVAL_G edge, not a separate cycle.
- Latency: RD rises on the 3rd rising edge, counting the edge that samples ST=1 as the 1st.
- Operands: captured only at start acceptance. Changing IN* afterwards has no effect on the in-flight result.
- ST while busy (EVAL_G, EVAL_F): ignored, no queuing.
- DONE:
  - RD=1 and RES are held stable indefinitely.
  - ST=1 in DONE is accepted as a new start: operands are latched, RD falls on that same edge, go to EVAL_G. RES keeps its old value until overwritten.
- ST pulse width: a single-cycle pulse is sufficient. ST held high re-triggers only from IDLE or DONE.
- RD is a level, not a pulse. There is no acknowledge input.
- No X propagation: every register has a defined reset value.

Decomposition:
- Shared package node_pkg:
  - WIDTH default constant.
  - State enum {IDLE, EVAL_G, EVAL_F, DONE}.
  - Function names for g0/g1/g2/f, so sibling nodes reuse them.
- One sub-module, node0_inner: purely combinational; takes the three operands and produces g0, g1, g2.
- Outer sum f and the FSM stay in node0.

Test Plan:
- Basic: RST=0 for 2 cycles, then RST=1; IN0=IN1=IN2=4; 1-cycle ST pulse -> RD=0 on the 1st and 2nd edges, RD=1 on the 3rd; RES=24 (g=8,16,0).
- Wrap: IN0=0xFFFF, IN1=0x0001, IN2=0x0100, start -> RES=0x0201 (g0=0, g1=0x0100, g2=0x0101).
- Multiply overflow: IN0=0, IN1=0x0100, IN2=0x0100 -> g1=0, RES=0x0200.
- Operand isolation and busy ignore: start with 4,4,4, then change IN* to 1,1,1 and pulse ST while in EVAL_G -> RES=24, RD at the original 3rd edge only.
- Restart from DONE: after RES=24 with RD=1, start with IN0=1, IN1=2, IN2=3 -> RD falls next edge, then RD=1 with RES=0x000B two edges later (3+6+2).
- Reset mid-operation: start, then RST=0 in EVAL_F -> next edge RD=0 and RES=0; no RD pulse appears afterwards.

Source files
------------

// File: rtl/node_pkg.sv
// Shared definitions for the "operation o" composition nodes: default width,
// node state encoding and the g/f arithmetic reused by sibling nodes.
package node_pkg;

  localparam int unsigned NODE_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVAL_G = 2'd1,
    EVAL_F = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic logic [NODE_WIDTH-1:0] calc_g0(input logic [NODE_WIDTH-1:0] x0,
                                                    input logic [NODE_WIDTH-1:0] x1);
    return NODE_WIDTH'(x0 + x1);
  endfunction

  function automatic logic [NODE_WIDTH-1:0] calc_g1(input logic [NODE_WIDTH-1:0] x1,
                                                    input logic [NODE_WIDTH-1:0] x2);
    return NODE_WIDTH'(x1 * x2);
  endfunction

  function automatic logic [NODE_WIDTH-1:0] calc_g2(input logic [NODE_WIDTH-1:0] x0,
                                                    input logic [NODE_WIDTH-1:0] x2);
    return NODE_WIDTH'(x2 - x0);
  endfunction

  function automatic logic [NODE_WIDTH-1:0] calc_f(input logic [NODE_WIDTH-1:0] g0,
                                                   input logic [NODE_WIDTH-1:0] g1,
                                                   input logic [NODE_WIDTH-1:0] g2);
    return NODE_WIDTH'(g0 + g1 + g2);
  endfunction

endpackage

// File: rtl/node0_inner.sv
// Combinational inner stage of node0: the three g functions of the operands,
// all modulo 2^WIDTH.
module node0_inner
  import node_pkg::*;
#(
  parameter int unsigned WIDTH = NODE_WIDTH
) (
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  output logic [WIDTH-1:0] g0,
  output logic [WIDTH-1:0] g1,
  output logic [WIDTH-1:0] g2
);

  always_comb begin
    g0 = WIDTH'(x0 + x1);
    g1 = WIDTH'(x1 * x2);
    g2 = WIDTH'(x2 - x0);
  end

endmodule

// File: rtl/node0.sv
// Leaf node computing f(g0(x), g1(x), g2(x)) with a start/ready handshake and a
// fixed three-edge latency from accepted start to RD.
module node0
  import node_pkg::*;
#(
  parameter int unsigned WIDTH = NODE_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ST,
  output logic             RD,
  output logic [WIDTH-1:0] RES,
  input  logic [WIDTH-1:0] IN0,
  input  logic [WIDTH-1:0] IN1,
  input  logic [WIDTH-1:0] IN2
);

  state_t           state;
  logic [WIDTH-1:0] op0, op1, op2;
  logic [WIDTH-1:0] g0_q, g1_q, g2_q;
  logic [WIDTH-1:0] g0_c, g1_c, g2_c;
  logic [WIDTH-1:0] f_c;
  logic             rd;
  logic [WIDTH-1:0] res;

  node0_inner #(.WIDTH(WIDTH)) u_inner (
    .x0 (op0),
    .x1 (op1),
    .x2 (op2),
    .g0 (g0_c),
    .g1 (g1_c),
    .g2 (g2_c)
  );

  assign f_c = WIDTH'(g0_q + g1_q + g2_q);

  // Start is accepted only in IDLE or DONE; busy states ignore ST.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= IDLE;
      op0   <= '0;
      op1   <= '0;
      op2   <= '0;
      g0_q  <= '0;
      g1_q  <= '0;
      g2_q  <= '0;
      rd    <= 1'b0;
      res   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (ST) begin
            op0   <= IN0;
            op1   <= IN1;
            op2   <= IN2;
            rd    <= 1'b0;
            state <= EVAL_G;
          end
        end
        EVAL_G: begin
          g0_q  <= g0_c;
          g1_q  <= g1_c;
          g2_q  <= g2_c;
          state <= EVAL_F;
        end
        EVAL_F: begin
          res   <= f_c;
          rd    <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign RD  = rd;
  assign RES = res;

endmodule

// File: tb/tb_node0.sv
// Self-checking bench for node0: directed scenarios plus randomized operations
// against an arithmetic reference model.
module tb_node0;

  logic        CLK;
  logic        RST;
  logic        ST;
  logic        RD;
  logic [15:0] RES;
  logic [15:0] IN0, IN1, IN2;

  int pass_cnt;
  int total_cnt;

  node0 dut (
    .CLK (CLK),
    .RST (RST),
    .ST  (ST),
    .RD  (RD),
    .RES (RES),
    .IN0 (IN0),
    .IN1 (IN1),
    .IN2 (IN2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: f = (x0+x1) + x1*x2 + (x2-x0), reduced mod 2^16.
  function automatic logic [15:0] model_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] c);
    longint s;
    s = (longint'(a) + longint'(b)) + longint'(b) * longint'(c) + (longint'(c) - longint'(a));
    return 16'(s & 64'hFFFF);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Start with given operands; check RD low on edges 1-2, high with result on edge 3.
  // With noisy set, operands are scrambled and ST toggled while busy.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                        input bit noisy, input string tag);
    logic [15:0] exp;
    exp = model_f(a, b, c);
    IN0 = a; IN1 = b; IN2 = c; ST = 1'b1;
    tick();
    ST = 1'b0;
    if (noisy) begin
      IN0 = 16'($urandom); IN1 = 16'($urandom); IN2 = 16'($urandom);
      ST = 1'($urandom_range(0, 1));
    end
    total_cnt++;
    if (RD !== 1'b0) $display("FAIL %s rd_edge1 got=%b exp=0", tag, RD);
    else pass_cnt++;
    tick();
    if (noisy) begin
      IN0 = 16'($urandom); IN1 = 16'($urandom); IN2 = 16'($urandom);
      ST = 1'($urandom_range(0, 1));
    end
    total_cnt++;
    if (RD !== 1'b0) $display("FAIL %s rd_edge2 got=%b exp=0", tag, RD);
    else pass_cnt++;
    tick();
    ST = 1'b0;
    total_cnt++;
    if (RD !== 1'b1 || RES !== exp)
      $display("FAIL %s result got rd=%b res=%h exp rd=1 res=%h", tag, RD, RES, exp);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    RST = 1'b0; ST = 1'b0; IN0 = '0; IN1 = '0; IN2 = '0;
    tick();
    tick();
    total_cnt++;
    if (RD !== 1'b0 || RES !== 16'h0000)
      $display("FAIL reset got rd=%b res=%h exp rd=0 res=0000", RD, RES);
    else pass_cnt++;
    RST = 1'b1;
    tick();
    total_cnt++;
    if (RD !== 1'b0 || RES !== 16'h0000)
      $display("FAIL reset_idle got rd=%b res=%h exp rd=0 res=0000", RD, RES);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    run_op(16'd4, 16'd4, 16'd4, 1'b0, "basic");
    total_cnt++;
    if (RES !== 16'd24) $display("FAIL basic_abs got=%h exp=0018", RES);
    else pass_cnt++;
    repeat (3) begin
      tick();
      total_cnt++;
      if (RD !== 1'b1 || RES !== 16'd24)
        $display("FAIL basic_hold got rd=%b res=%h exp rd=1 res=0018", RD, RES);
      else pass_cnt++;
    end
  endtask

  task automatic test_wrap();
    run_op(16'hFFFF, 16'h0001, 16'h0100, 1'b0, "wrap");
    total_cnt++;
    if (RES !== 16'h0201) $display("FAIL wrap_abs got=%h exp=0201", RES);
    else pass_cnt++;
  endtask

  task automatic test_mul_overflow();
    run_op(16'h0000, 16'h0100, 16'h0100, 1'b0, "mul_ovf");
    total_cnt++;
    if (RES !== 16'h0200) $display("FAIL mul_ovf_abs got=%h exp=0200", RES);
    else pass_cnt++;
  endtask

  task automatic test_busy_ignore();
    IN0 = 16'd4; IN1 = 16'd4; IN2 = 16'd4; ST = 1'b1;
    tick();
    IN0 = 16'd1; IN1 = 16'd1; IN2 = 16'd1; ST = 1'b1;
    tick();
    ST = 1'b0;
    total_cnt++;
    if (RD !== 1'b0) $display("FAIL busy_rd_edge2 got=%b exp=0", RD);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (RD !== 1'b1 || RES !== 16'd24)
      $display("FAIL busy_result got rd=%b res=%h exp rd=1 res=0018", RD, RES);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (RD !== 1'b1 || RES !== 16'd24)
      $display("FAIL busy_no_retrigger got rd=%b res=%h exp rd=1 res=0018", RD, RES);
    else pass_cnt++;
  endtask

  task automatic test_restart();
    IN0 = 16'd1; IN1 = 16'd2; IN2 = 16'd3; ST = 1'b1;
    tick();
    ST = 1'b0;
    total_cnt++;
    if (RD !== 1'b0 || RES !== 16'd24)
      $display("FAIL restart_edge1 got rd=%b res=%h exp rd=0 res=0018", RD, RES);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (RD !== 1'b0) $display("FAIL restart_edge2 got=%b exp=0", RD);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (RD !== 1'b1 || RES !== 16'h000B)
      $display("FAIL restart_result got rd=%b res=%h exp rd=1 res=000b", RD, RES);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    IN0 = 16'd7; IN1 = 16'd9; IN2 = 16'd5; ST = 1'b1;
    tick();
    ST = 1'b0;
    tick();
    RST = 1'b0;
    tick();
    total_cnt++;
    if (RD !== 1'b0 || RES !== 16'h0000)
      $display("FAIL reset_mid got rd=%b res=%h exp rd=0 res=0000", RD, RES);
    else pass_cnt++;
    RST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total_cnt++;
      if (RD !== 1'b0 || RES !== 16'h0000)
        $display("FAIL reset_mid_quiet cyc=%0d got rd=%b res=%h exp rd=0 res=0000", i, RD, RES);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b, c, exp;
    for (int n = 0; n < 40; n++) begin
      a = 16'($urandom); b = 16'($urandom); c = 16'($urandom);
      if (n % 8 == 0) a = 16'hFFFF;
      if (n % 8 == 1) begin b = 16'hFFFF; c = 16'hFFFF; end
      run_op(a, b, c, 1'($urandom_range(0, 1)), "random");
      exp = model_f(a, b, c);
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        IN0 = 16'($urandom); IN1 = 16'($urandom); IN2 = 16'($urandom);
        tick();
        total_cnt++;
        if (RD !== 1'b1 || RES !== exp)
          $display("FAIL random_hold got rd=%b res=%h exp rd=1 res=%h", RD, RES, exp);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_mul_overflow();
    test_busy_ignore();
    test_restart();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
